// File: rtl/out_fm_pkg.sv
// Shared types for the out-FM store controller.
//   st_state_t    : controller FSM states
//   ST_FIFO_DEPTH : skid FIFO depth (two entries cover the 1-cycle buffer
//                   read latency plus one cycle of write-port response)
//   st_entry_t    : one skid FIFO entry, {memory word address, data}
package out_fm_pkg;

    localparam int ST_FIFO_DEPTH = 2;
    localparam int ST_MW         = 32;
    localparam int ST_DW         = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        FLUSH = 2'd2,
        DONE  = 2'd3
    } st_state_t;

    typedef struct packed {
        logic [ST_MW-1:0] addr;
        logic [ST_DW-1:0] data;
    } st_entry_t;

endpackage

// File: rtl/out_fm_st_skid_fifo.sv
// Two-entry synchronous skid FIFO for the out-FM store path.
//   clk, rst   : clock, async active-high reset (clears contents and count)
//   push       : write push_entry at the tail
//   push_entry : {addr, data} to store
//   pop        : drop the head entry (only asserted while cnt != 0)
//   head       : oldest entry, held stable until popped
//   cnt        : number of valid entries (0..2)
module out_fm_st_skid_fifo
    import out_fm_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  st_entry_t  push_entry,
    input  logic       pop,
    output st_entry_t  head,
    output logic [1:0] cnt
);

    st_entry_t mem [ST_FIFO_DEPTH];
    // Depth is 2, so single-bit pointers toggle between the two slots.
    logic      wptr;
    logic      rptr;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr <= 1'b0;
            rptr <= 1'b0;
            cnt  <= 2'd0;
            for (int i = 0; i < ST_FIFO_DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wptr] <= push_entry;
                wptr      <= ~wptr;
            end
            if (pop) rptr <= ~rptr;
            case ({push, pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

    assign head = mem[rptr];

endmodule

// File: rtl/out_fm_st_ctrl.sv
// Output-feature-map store controller.
// Walks a row_num x col_num tile in row-major order, reads each element from
// the on-chip output buffer (1-cycle latency) and pushes {addr, data} onto a
// valid/ready write port through a 2-entry skid FIFO.
//   clk, rst      : clock, async active-high reset (aborts, no done pulse)
//   start         : one-cycle tile request, honoured in IDLE only
//   base_addr     : memory word address of element (0,0)
//   row_num/col_num : tile dimensions (either zero -> straight to DONE)
//   row_stride    : memory word distance between tile rows
//   buf_rd_en/addr, buf_rd_data : output buffer read port
//   wr_valid/ready/addr/data     : memory write port
//   busy          : high in RUN and FLUSH
//   done          : one-cycle pulse after the last write handshake
module out_fm_st_ctrl
    import out_fm_pkg::*;
#(
    parameter int CW = 16,
    parameter int AW = 16,
    parameter int DW = ST_DW,   // entry width is fixed by st_entry_t
    parameter int MW = ST_MW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [MW-1:0] base_addr,
    input  logic [CW-1:0] row_num,
    input  logic [CW-1:0] col_num,
    input  logic [MW-1:0] row_stride,
    output logic          buf_rd_en,
    output logic [AW-1:0] buf_rd_addr,
    input  logic [DW-1:0] buf_rd_data,
    output logic          wr_valid,
    input  logic          wr_ready,
    output logic [MW-1:0] wr_addr,
    output logic [DW-1:0] wr_data,
    output logic          busy,
    output logic          done
);

    st_state_t     state, state_nxt;
    logic [CW-1:0] row_n, col_n, row_cnt, col_cnt;
    logic [MW-1:0] stride, row_base, maddr_q;
    logic [AW-1:0] rd_addr;
    logic          inflight;      // buffer read issued last cycle
    logic [1:0]    fifo_cnt;
    logic [1:0]    occ;
    logic          hs, col_last, last_issue;
    st_entry_t     push_entry, head;

    // Credit rule: a read may issue only if its data is guaranteed a FIFO
    // slot, counting entries already stored plus the read in flight. A pop
    // this cycle frees a slot, keeping 1 element/cycle with wr_ready high.
    always_comb begin
        occ        = fifo_cnt + {1'b0, inflight};
        hs         = wr_valid & wr_ready;
        buf_rd_en  = (state == RUN) && ((occ < 2'd2) || hs);
        col_last   = (col_cnt == col_n - CW'(1));
        last_issue = buf_rd_en && col_last && (row_cnt == row_n - CW'(1));
        busy       = (state == RUN) || (state == FLUSH);
        done       = (state == DONE);
        state_nxt  = state;
        case (state)
            IDLE:    if (start)
                         state_nxt = (row_num == '0 || col_num == '0) ? DONE : RUN;
            RUN:     if (last_issue) state_nxt = FLUSH;
            // Last handshake: the only remaining entry pops, nothing in flight.
            FLUSH:   if (hs && fifo_cnt == 2'd1 && !inflight) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Issue counters. Memory address is row_base + col, with row_base
    // accumulating row_stride on each column wrap (no multiplier).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_n    <= '0;
            col_n    <= '0;
            stride   <= '0;
            row_base <= '0;
            row_cnt  <= '0;
            col_cnt  <= '0;
            rd_addr  <= '0;
            maddr_q  <= '0;
            inflight <= 1'b0;
        end else begin
            inflight <= buf_rd_en;
            if (state == IDLE && start) begin
                row_n    <= row_num;
                col_n    <= col_num;
                stride   <= row_stride;
                row_base <= base_addr;
                row_cnt  <= '0;
                col_cnt  <= '0;
                rd_addr  <= '0;
            end else if (buf_rd_en) begin
                maddr_q <= row_base + MW'(col_cnt);
                rd_addr <= rd_addr + AW'(1);
                if (col_last) begin
                    col_cnt  <= '0;
                    row_cnt  <= row_cnt + CW'(1);
                    row_base <= row_base + stride;
                end else begin
                    col_cnt  <= col_cnt + CW'(1);
                end
            end
        end
    end

    assign buf_rd_addr     = rd_addr;
    assign push_entry.addr = maddr_q;
    assign push_entry.data = buf_rd_data;

    out_fm_st_skid_fifo u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (inflight),
        .push_entry (push_entry),
        .pop        (hs),
        .head       (head),
        .cnt        (fifo_cnt)
    );

    assign wr_valid = (fifo_cnt != 2'd0);
    assign wr_addr  = head.addr;
    assign wr_data  = head.data;

endmodule
